// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time imem writer: byte stream to big-endian words, core held in reset until loaded
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR, S_LOAD, S_WRITE, S_RUN, S_ERR, S_CHK} state_t;
`else
    typedef enum logic [2:0] {S_HDR, S_LOAD, S_WRITE, S_RUN, S_ERR} state_t;
`endif

    state_t            state, next_state;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [31:0]       len;
    logic [31:0]       shift;
    logic [31:0]       shifted;
    logic              ready_st;
    logic              accept;
    state_t            done_state;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // Where the FSM goes once every payload word is written (or N=0).
`ifdef LOADER_CHECKSUM_EN
    assign done_state = S_CHK;
`else
    assign done_state = S_RUN;
`endif

    assign shifted  = {shift[23:0], in_data};
    assign in_ready = reset & ready_st;
    assign accept   = in_valid & in_ready;

    always_comb begin
        next_state = state;
        ready_st   = 1'b0;
        case (state)
            S_HDR: begin
                ready_st = 1'b1;
                if (accept && byte_cnt == 2'd3) begin
                    if (shifted == 32'd0)
                        next_state = done_state;
                    else if (shifted > 32'(MAX_WORDS))
                        next_state = S_ERR;
                    else
                        next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                ready_st = 1'b1;
                if (accept && byte_cnt == 2'd3)
                    next_state = S_WRITE;
            end
            S_WRITE: begin
                if (32'(word_cnt) + 32'd1 == len)
                    next_state = done_state;
                else
                    next_state = S_LOAD;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                ready_st = 1'b1;
                if (accept)
                    next_state = (in_data == csum) ? S_RUN : S_ERR;
            end
`endif
            S_RUN:   next_state = S_RUN;
            S_ERR:   next_state = S_ERR;
            default: next_state = S_HDR;
        endcase
    end

    // Outputs are registered from next_state so WRITE/RUN/ERR decode appears the cycle the state is entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_HDR;
            byte_cnt   <= 2'd0;
            word_cnt   <= '0;
            len        <= 32'd0;
            shift      <= 32'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            state <= next_state;
            if (accept && (state == S_HDR || state == S_LOAD)) begin
                shift    <= shifted;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (accept && state == S_HDR && byte_cnt == 2'd3)
                len <= shifted;
`ifdef LOADER_CHECKSUM_EN
            if (accept && state == S_LOAD)
                csum <= csum ^ in_data;
`endif
            if (state == S_WRITE)
                word_cnt <= word_cnt + 1'b1;
            imem_we <= (next_state == S_WRITE);
            if (state == S_LOAD && next_state == S_WRITE) begin
                imem_addr  <= word_cnt[ADDR_W-1:0];
                imem_wdata <= shifted;
            end
            core_rst <= (next_state != S_RUN);
            done     <= (next_state == S_RUN);
            error    <= (next_state == S_ERR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;

    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    logic        mon_stall = 1'b0;
    int          stalls = 0;

    program_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
        if (mon_stall && !in_ready && !imem_we && !done && !error)
            stalls++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic idle(input int n);
        #1 in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Checksum byte only exists in the checksum build.
    task automatic send_csum(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
        send_byte(c);
`else
        c = c;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        wa.delete();
        wd.delete();
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {24'd0, imem_addr}, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b1;

        // N=2, continuous stream
        send_word(32'h0000_0002, 0);
        send_word(32'h2408_0005, 0);
        send_word(32'h8C09_0004, 0);
`ifndef LOADER_CHECKSUM_EN
        idle(0);
        @(negedge clk);
        check("n2_we_lat", {31'd0, imem_we}, 32'd1);
        check("n2_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("n2_done_lat", {31'd0, done}, 32'd1);
        check("n2_core_rst", {31'd0, core_rst}, 32'd0);
`else
        send_csum(8'hA8);
        idle(0);
        @(negedge clk);
`endif
        repeat (2) @(negedge clk);
        check("n2_done", {31'd0, done}, 32'd1);
        check("n2_nwrites", wa.size(), 32'd2);
        if (wa.size() == 2) begin
            check("n2_a0", {24'd0, wa[0]}, 32'd0);
            check("n2_d0", wd[0], 32'h2408_0005);
            check("n2_a1", {24'd0, wa[1]}, 32'd1);
            check("n2_d1", wd[1], 32'h8C09_0004);
        end

        // N=0
        do_reset();
        send_word(32'h0000_0000, 0);
        send_csum(8'h00);
        idle(0);
        @(negedge clk);
        check("n0_done", {31'd0, done}, 32'd1);
        check("n0_core_rst", {31'd0, core_rst}, 32'd0);
        check("n0_in_ready", {31'd0, in_ready}, 32'd0);
        check("n0_nwrites", wa.size(), 32'd0);

        // N=300 exceeds MAX_WORDS
        do_reset();
        send_word(32'h0000_012C, 0);
        idle(0);
        @(negedge clk);
        check("big_error", {31'd0, error}, 32'd1);
        check("big_in_ready", {31'd0, in_ready}, 32'd0);
        check("big_core_rst", {31'd0, core_rst}, 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        check("big_still_err", {31'd0, error}, 32'd1);
        check("big_done", {31'd0, done}, 32'd0);
        check("big_nwrites", wa.size(), 32'd0);

        // N=1 with gaps between every byte
        do_reset();
        stalls    = 0;
        mon_stall = 1'b1;
        send_word(32'h0000_0001, 3);
        send_word(32'hAABB_CCDD, 3);
        send_csum(8'h00);
        idle(4);
        mon_stall = 1'b0;
        check("gap_stalls", stalls, 32'd0);
        check("gap_done", {31'd0, done}, 32'd1);
        check("gap_nwrites", wa.size(), 32'd1);
        if (wa.size() == 1) begin
            check("gap_a0", {24'd0, wa[0]}, 32'd0);
            check("gap_d0", wd[0], 32'hAABB_CCDD);
        end

        // Reset in the middle of word 1 of an N=3 image, then a fresh N=1 image
        do_reset();
        send_word(32'h0000_0003, 0);
        send_word(32'h1122_3344, 0);
        send_byte(8'h55);
        @(negedge clk);
        in_data = 8'h66;
        reset   = 1'b0;
        #1;
        check("mid_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("mid_we", {31'd0, imem_we}, 32'd0);
        check("mid_core_rst", {31'd0, core_rst}, 32'd1);
        in_valid = 1'b0;
        wa.delete();
        wd.delete();
        reset = 1'b1;
        send_word(32'h0000_0001, 0);
        send_word(32'hDEAD_BEEF, 0);
        send_csum(8'h22);
        idle(4);
        check("mid_done", {31'd0, done}, 32'd1);
        check("mid_error", {31'd0, error}, 32'd0);
        check("mid_nwrites", wa.size(), 32'd1);
        if (wa.size() == 1) begin
            check("mid_a0", {24'd0, wa[0]}, 32'd0);
            check("mid_d0", wd[0], 32'hDEAD_BEEF);
        end

`ifdef LOADER_CHECKSUM_EN
        // Good and bad checksum for payload 01 02 03 04
        do_reset();
        send_word(32'h0000_0001, 0);
        send_word(32'h0102_0304, 0);
        send_byte(8'h04);
        idle(0);
        @(negedge clk);
        check("ck_ok_done", {31'd0, done}, 32'd1);
        check("ck_ok_error", {31'd0, error}, 32'd0);
        do_reset();
        send_word(32'h0000_0001, 0);
        send_word(32'h0102_0304, 0);
        send_byte(8'h05);
        idle(2);
        check("ck_bad_error", {31'd0, error}, 32'd1);
        check("ck_bad_core_rst", {31'd0, core_rst}, 32'd1);
        check("ck_bad_done", {31'd0, done}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
